alu_cmd_issuer: RTL and testbench

//   Sequencing front end for the combinational V-bit ALU: accepts opcode/operand commands over

---
 rtl/alu_cmd_issuer.sv | 111 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command/response sequencer in front of the combinational V-bit ALU
// One command in flight: IDLE accepts, DRIVE holds ALU inputs for SETTLE cycles, RESP returns the capture.
module alu_cmd_issuer #(
  parameter int V      = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         init,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_opco,
  input  logic [V-1:0] cmd_a,
  input  logic [V-1:0] cmd_b,
  output logic         alu_init,
  output logic [3:0]   alu_opco,
  output logic [V-1:0] alu_a,
  output logic [V-1:0] alu_b,
  input  logic [15:0]  alu_out,
  input  logic [4:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [15:0]  rsp_data,
  output logic [4:0]   rsp_flags,
  output logic [3:0]   rsp_opco,
  output logic         busy,
  output logic [7:0]   issued_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t         state_q;
  logic           alu_init_q;
  logic [3:0]     alu_opco_q;
  logic [V-1:0]   alu_a_q;
  logic [V-1:0]   alu_b_q;
  logic           rsp_valid_q;
  logic [15:0]    rsp_data_q;
  logic [4:0]     rsp_flags_q;
  logic [3:0]     rsp_opco_q;
  logic [7:0]     issued_cnt_q;
  logic [7:0]     issued_cnt_d;
  logic [CW-1:0]  settle_q;
  logic           accept;

  // In RESP a new command may be taken on the same edge the response is popped.
  assign cmd_ready    = alu_init_q && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign accept       = cmd_valid && cmd_ready;
  assign issued_cnt_d = issued_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q      <= IDLE;
      alu_init_q   <= 1'b0;
      alu_opco_q   <= 4'h0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 16'h0000;
      rsp_flags_q  <= 5'h00;
      rsp_opco_q   <= 4'h0;
      issued_cnt_q <= 8'h00;
      settle_q     <= '0;
    end else begin
      alu_init_q <= 1'b1;
      if (accept) begin
        alu_opco_q   <= cmd_opco;
        alu_a_q      <= cmd_a;
        alu_b_q      <= cmd_b;
        issued_cnt_q <= issued_cnt_d;
        settle_q     <= CW'(SETTLE - 1);
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= DRIVE;
        end
        DRIVE: begin
          if (settle_q == '0) begin
            rsp_data_q  <= alu_out;
            rsp_flags_q <= alu_flags;
            rsp_opco_q  <= alu_opco_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? DRIVE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_init   = alu_init_q;
  assign alu_opco   = alu_opco_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_opco   = rsp_opco_q;
  assign busy       = (state_q != IDLE);
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer with a behavioural ALU stub
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opco = 4'h0;
  logic [7:0]  cmd_a = 8'h00;
  logic [7:0]  cmd_b = 8'h00;
  logic        alu_init;
  logic [3:0]  alu_opco;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic [3:0]  rsp_opco;
  logic        busy;
  logic [7:0]  issued_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_issued = 0;

  alu_cmd_issuer #(.V(8), .SETTLE(1)) dut (
    .clk(clk), .init(init), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opco(cmd_opco), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_init(alu_init),
    .alu_opco(alu_opco), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_opco(rsp_opco),
    .busy(busy), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {flags, out}, flags = {done, shift, zero, log, carry}.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] d;
    logic        c;
    logic [8:0]  s;
    c = 1'b0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'h1: begin d = {8'h00, s[7:0]}; c = s[8]; end
      4'h2: begin d = {8'h00, a - b}; c = (a < b); end
      4'h3: d = 16'(a) * 16'(b);
      4'h4: if (b == 8'h00) begin d = 16'h0000; c = 1'b1; end else d = {8'h00, a / b};
      4'h5: d = {8'h00, a & b};
      default: d = {a, b} ^ {12'h000, op};
    endcase
    return {1'b1, op[3], (d == 16'h0000), (op == 4'h5), c, d};
  endfunction

  always_comb {alu_flags, alu_out} = alu_model(alu_opco, alu_a, alu_b);

  // Entered near a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    cmd_opco = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cmd_ready) begin ok = 1'b1; exp_issued++; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++; if (alu_init !== 1'b0) begin n_bad++; $display("FAIL rst_alu_init: got %b want 0", alu_init); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (issued_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_issued: got %h want 00", issued_cnt); end
    n_cmp++; if ({busy, alu_opco, alu_a, alu_b, rsp_data, rsp_flags, rsp_opco} !== 46'h0) begin
      n_bad++; $display("FAIL rst_regs: got busy=%b opco=%h a=%h b=%h d=%h f=%h o=%h want all 0",
                        busy, alu_opco, alu_a, alu_b, rsp_data, rsp_flags, rsp_opco); end
    init = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rel_cmd_ready_pre: got %b want 0", cmd_ready); end
    @(negedge clk);
    n_cmp++; if (alu_init !== 1'b1) begin n_bad++; $display("FAIL rel_alu_init: got %b want 1", alu_init); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_add();
    bit ok;
    send_cmd(4'h1, 8'hF0, 8'h20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL add_accept: got timeout want accept"); end
    n_cmp++; if ({alu_opco, alu_a, alu_b} !== {4'h1, 8'hF0, 8'h20}) begin n_bad++;
      $display("FAIL add_alu_in: got %h/%h/%h want 1/f0/20", alu_opco, alu_a, alu_b); end
    n_cmp++; if ({rsp_valid, busy, cmd_ready} !== 3'b010) begin n_bad++;
      $display("FAIL add_drive: got v/busy/rdy=%b%b%b want 010", rsp_valid, busy, cmd_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'h0010) begin n_bad++; $display("FAIL add_data: got %h want 0010", rsp_data); end
    n_cmp++; if (rsp_flags[0] !== 1'b1) begin n_bad++; $display("FAIL add_carry: got %b want 1", rsp_flags[0]); end
    n_cmp++; if (rsp_opco !== 4'h1) begin n_bad++; $display("FAIL add_opco: got %h want 1", rsp_opco); end
    n_cmp++; if (issued_cnt !== 8'(exp_issued)) begin n_bad++; $display("FAIL add_issued: got %h want %h", issued_cnt, 8'(exp_issued)); end
    pop_rsp();
    n_cmp++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin n_bad++;
      $display("FAIL add_pop: got v/busy/rdy=%b%b%b want 001", rsp_valid, busy, cmd_ready); end
    n_cmp++; if ({alu_opco, alu_a, alu_b} !== {4'h1, 8'hF0, 8'hF0 ^ 8'hD0}) begin n_bad++;
      $display("FAIL add_hold: got %h/%h/%h want 1/f0/20", alu_opco, alu_a, alu_b); end
  endtask

  task automatic test_stall();
    bit ok;
    send_cmd(4'h3, 8'h10, 8'h10, ok);
    wait_rsp(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mul_rsp: got timeout want rsp_valid"); end
    cmd_opco = 4'h5; cmd_a = 8'h0F; cmd_b = 8'h3C; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 16'h0100, 1'b0}) begin n_bad++;
        $display("FAIL mul_stall: got v=%b d=%h rdy=%b want 1/0100/0", rsp_valid, rsp_data, cmd_ready); end
      n_cmp++; if (issued_cnt !== 8'(exp_issued)) begin n_bad++; $display("FAIL mul_issued: got %h want %h", issued_cnt, 8'(exp_issued)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    if (cmd_ready) exp_issued++;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, busy, alu_a, alu_b} !== {2'b01, 8'h0F, 8'h3C}) begin n_bad++;
      $display("FAIL b2b_drive: got v=%b busy=%b a=%h b=%h want 0/1/0f/3c", rsp_valid, busy, alu_a, alu_b); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 16'h000C}) begin n_bad++;
      $display("FAIL b2b_data: got v=%b d=%h want 1/000c", rsp_valid, rsp_data); end
    n_cmp++; if (issued_cnt !== 8'(exp_issued)) begin n_bad++; $display("FAIL b2b_issued: got %h want %h", issued_cnt, 8'(exp_issued)); end
    pop_rsp();
  endtask

  task automatic test_div_zero();
    bit ok;
    send_cmd(4'h4, 8'h40, 8'h00, ok);
    wait_rsp(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL div_rsp: got timeout want rsp_valid"); end
    n_cmp++; if ({rsp_data, rsp_flags[0], rsp_opco} !== {16'h0000, 1'b1, 4'h4}) begin n_bad++;
      $display("FAIL div_zero: got d=%h c=%b o=%h want 0000/1/4", rsp_data, rsp_flags[0], rsp_opco); end
    pop_rsp();
  endtask

  task automatic test_random();
    bit ok;
    logic [3:0] op; logic [7:0] a, b; logic [20:0] exp;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
      exp = alu_model(op, a, b);
      send_cmd(op, a, b, ok);
      wait_rsp(ok);
      for (int h = 0; h <= int'($urandom_range(0, 3)); h++) begin
        #1;
        n_cmp++; if ({ok, rsp_flags, rsp_data, rsp_opco} !== {1'b1, exp, op}) begin n_bad++;
          $display("FAIL rnd_rsp: got ok=%b f=%h d=%h o=%h want f=%h d=%h o=%h", ok, rsp_flags, rsp_data, rsp_opco, exp[20:16], exp[15:0], op); end
        @(negedge clk);
      end
      n_cmp++; if (issued_cnt !== 8'(exp_issued)) begin n_bad++; $display("FAIL rnd_issued: got %h want %h", issued_cnt, 8'(exp_issued)); end
      pop_rsp();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_cmd(4'h1, 8'h12, 8'h34, ok);
    init = 1'b0;
    exp_issued = 0;
    #1;
    n_cmp++; if ({rsp_valid, busy, cmd_ready, alu_init, issued_cnt, alu_a} !== 20'h0) begin n_bad++;
      $display("FAIL midrst: got v=%b busy=%b rdy=%b ai=%b cnt=%h a=%h want all 0", rsp_valid, busy, cmd_ready, alu_init, issued_cnt, alu_a); end
    @(negedge clk); @(negedge clk);
    init = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({rsp_valid, cmd_ready, issued_cnt} !== {2'b01, 8'h00}) begin n_bad++;
      $display("FAIL midrst_rel: got v=%b rdy=%b cnt=%h want 0/1/00", rsp_valid, cmd_ready, issued_cnt); end
  endtask

  task automatic test_wrap();
    logic [24:0] q[$];
    logic [24:0] got;
    int cyc = 0;
    bit newcmd = 1'b1;
    rsp_ready = 1'b1;
    while (exp_issued < 256 && cyc < 3000) begin
      if (newcmd) begin
        cmd_opco = 4'($urandom_range(0, 15)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        cmd_valid = 1'b1; newcmd = 1'b0;
      end
      #1;
      if (rsp_valid && rsp_ready) begin
        got = {rsp_opco, rsp_flags, rsp_data};
        n_cmp++; if (q.size() == 0 || got !== q[0]) begin n_bad++; $display("FAIL wrap_rsp: got %h want %h", got, (q.size() == 0) ? 25'h0 : q[0]); end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        q.push_back({cmd_opco, alu_model(cmd_opco, cmd_a, cmd_b)});
        exp_issued++; newcmd = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    n_cmp++; if (exp_issued != 256) begin n_bad++; $display("FAIL wrap_timeout: got %0d accepts want 256", exp_issued); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (issued_cnt !== 8'h00) begin n_bad++; $display("FAIL wrap_cnt: got %h want 00", issued_cnt); end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_back_to_back();
    test_div_zero();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
